si5338_i2c_master: RTL and testbench

Byte-oriented I2C master that consumes register transactions from the SI5338 configurer, i.e. the {register address, data} word, the read/write flag and the valid/ready handshake. It executes each transaction as a complete I2C bus sequence on open-drain SCL/SDA toward the SI5338. It returns the read byte and ready. It sits directly downstream of the configurer, between it and the board I2C pins.

---
 rtl/si5338_i2c_pkg.sv | 32 +++
 rtl/si5338_i2c_master_quarter_tick.sv | 42 ++++
 rtl/si5338_i2c_master.sv | 237 +++++++++++++++++++++++
 tb/tb_si5338_i2c_master.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/si5338_i2c_pkg.sv
// ============================================================================
// Module      : si5338_i2c_pkg
// Description : Shared FSM states and I2C bit constants for the SI5338 master.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package si5338_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_START   = 4'd1,
        ST_TX_BYTE = 4'd2,
        ST_RX_ACK  = 4'd3,
        ST_RSTART  = 4'd4,
        ST_RX_BYTE = 4'd5,
        ST_TX_NACK = 4'd6,
        ST_STOP    = 4'd7,
        ST_DONE    = 4'd8
    } i2c_state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h70;

endpackage

`default_nettype wire

// File: rtl/si5338_i2c_master_quarter_tick.sv
// ============================================================================
// Module      : i2c_quarter_tick
// Description : One-cycle tick every QTR clocks; clr restarts the count at 0.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module i2c_quarter_tick #(
    parameter int QTR = 62
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (QTR < 2) ? 1 : $clog2(QTR);
    localparam logic [CW-1:0] C_LAST = CW'(QTR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == C_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == C_LAST) && !clr;

endmodule

`default_nettype wire

// File: rtl/si5338_i2c_master.sv
// ============================================================================
// Module      : si5338_i2c_master
// Description : Byte-oriented I2C master executing SI5338 register reads/writes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module si5338_i2c_master
    import si5338_i2c_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 100_000_000,
    parameter int         SCL_FREQ_HZ = 400_000,
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rstn,
    input  logic [15:0] Data_i16b,
    input  logic        Rw_i,
    input  logic        Val_i,
    output logic        Rdy_o,
    output logic [7:0]  Data_o8b,
    output logic        Nack_o,
    output logic        Scl_oe_o,
    output logic        Sda_oe_o,
    input  logic        Sda_i
);

    localparam int QTR = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);

    generate
        if (QTR < 2) begin : g_qtr_check
            $error("si5338_i2c_master: CLK_FREQ_HZ/(4*SCL_FREQ_HZ) must be at least 2");
        end
    endgenerate

    i2c_state_e state_q;
    logic [1:0] qtr_q;
    logic [2:0] bit_q;
    logic [1:0] byte_q;
    logic [7:0] shift_q;
    logic [7:0] rx_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic [7:0] data_q;
    logic       rw_q;
    logic       ack_q;
    logic       rdy_q;
    logic       nack_q;
    logic       scl_oe_q;
    logic       sda_oe_q;
    logic       sda_s1_q;
    logic       sda_s2_q;
    logic       tick;
    logic [7:0] load_byte;

    i2c_quarter_tick #(
        .QTR (QTR)
    ) u_tick (
        .clk   (Clk),
        .rst_n (Rstn),
        .clr   (state_q == ST_IDLE),
        .tick  (tick)
    );

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            sda_s1_q <= Sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

    // Next byte to shift out whenever the FSM enters TX_BYTE.
    always_comb begin
        load_byte = wdata_q;
        if (state_q == ST_START) begin
            load_byte = {DEV_ADDR, I2C_WR};
        end else if (state_q == ST_RSTART) begin
            load_byte = {DEV_ADDR, I2C_RD};
        end else if (byte_q == 2'd0) begin
            load_byte = reg_q;
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q  <= ST_IDLE;
            qtr_q    <= 2'd0;
            bit_q    <= 3'd0;
            byte_q   <= 2'd0;
            shift_q  <= 8'h00;
            rx_q     <= 8'h00;
            reg_q    <= 8'h00;
            wdata_q  <= 8'h00;
            data_q   <= 8'h00;
            rw_q     <= I2C_WR;
            ack_q    <= ACK;
            rdy_q    <= 1'b1;
            nack_q   <= 1'b0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (Val_i && rdy_q) begin
                state_q  <= ST_START;
                qtr_q    <= 2'd0;
                byte_q   <= 2'd0;
                reg_q    <= Data_i16b[15:8];
                wdata_q  <= Data_i16b[7:0];
                rw_q     <= Rw_i;
                rdy_q    <= 1'b0;
                nack_q   <= 1'b0;
                sda_oe_q <= 1'b1;
            end
        end else if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            case (state_q)
                ST_START: begin
                    if (qtr_q == 2'd0) begin
                        scl_oe_q <= 1'b1;
                    end else begin
                        state_q  <= ST_TX_BYTE;
                        qtr_q    <= 2'd0;
                        bit_q    <= 3'd0;
                        shift_q  <= load_byte;
                        sda_oe_q <= ~load_byte[7];
                    end
                end
                ST_RSTART: begin
                    case (qtr_q)
                        2'd0: scl_oe_q <= 1'b0;
                        2'd1: sda_oe_q <= 1'b1;
                        2'd2: scl_oe_q <= 1'b1;
                        default: begin
                            state_q  <= ST_TX_BYTE;
                            bit_q    <= 3'd0;
                            byte_q   <= 2'd2;
                            shift_q  <= load_byte;
                            sda_oe_q <= ~load_byte[7];
                        end
                    endcase
                end
                ST_TX_BYTE, ST_RX_ACK, ST_RX_BYTE, ST_TX_NACK: begin
                    case (qtr_q)
                        2'd0: scl_oe_q <= 1'b0;
                        2'd1: ;
                        2'd2: begin
                            scl_oe_q <= 1'b1;
                            if (state_q == ST_RX_ACK) begin
                                ack_q <= sda_s2_q;
                            end
                            if (state_q == ST_RX_BYTE) begin
                                rx_q <= {rx_q[6:0], sda_s2_q};
                            end
                        end
                        default: begin
                            if (state_q == ST_TX_BYTE) begin
                                if (bit_q == 3'd7) begin
                                    state_q  <= ST_RX_ACK;
                                    sda_oe_q <= 1'b0;
                                end else begin
                                    bit_q    <= bit_q + 3'd1;
                                    shift_q  <= {shift_q[6:0], 1'b0};
                                    sda_oe_q <= ~shift_q[6];
                                end
                            end else if (state_q == ST_RX_BYTE) begin
                                bit_q <= bit_q + 3'd1;
                                if (bit_q == 3'd7) begin
                                    state_q  <= ST_TX_NACK;
                                    sda_oe_q <= 1'b0;
                                end
                            end else if (state_q == ST_TX_NACK) begin
                                state_q  <= ST_STOP;
                                sda_oe_q <= 1'b1;
                            end else if (ack_q == NACK) begin
                                nack_q   <= 1'b1;
                                state_q  <= ST_STOP;
                                sda_oe_q <= 1'b1;
                            end else if (byte_q == 2'd0 || (byte_q == 2'd1 && rw_q == I2C_WR)) begin
                                state_q  <= ST_TX_BYTE;
                                bit_q    <= 3'd0;
                                byte_q   <= byte_q + 2'd1;
                                shift_q  <= load_byte;
                                sda_oe_q <= ~load_byte[7];
                            end else if (byte_q == 2'd1) begin
                                state_q  <= ST_RSTART;
                                sda_oe_q <= 1'b0;
                            end else if (rw_q == I2C_RD) begin
                                state_q  <= ST_RX_BYTE;
                                bit_q    <= 3'd0;
                                sda_oe_q <= 1'b0;
                            end else begin
                                state_q  <= ST_STOP;
                                sda_oe_q <= 1'b1;
                            end
                        end
                    endcase
                end
                ST_STOP: begin
                    if (qtr_q == 2'd0) begin
                        scl_oe_q <= 1'b0;
                    end else begin
                        sda_oe_q <= 1'b0;
                        state_q  <= ST_DONE;
                        qtr_q    <= 2'd0;
                    end
                end
                ST_DONE: begin
                    // A full bit of bus-free time before the next START is allowed.
                    if (qtr_q == 2'd3) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                        if (rw_q == I2C_RD && !nack_q) begin
                            data_q <= rx_q;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    scl_oe_q <= 1'b0;
                    sda_oe_q <= 1'b0;
                    rdy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign Rdy_o    = rdy_q;
    assign Data_o8b = data_q;
    assign Nack_o   = nack_q;
    assign Scl_oe_o = scl_oe_q;
    assign Sda_oe_o = sda_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_si5338_i2c_master.sv
// ============================================================================
// Module      : tb_si5338_i2c_master
// Description : Directed bench for si5338_i2c_master with a bit-level slave.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_si5338_i2c_master;

    localparam int BIT = 248;

    logic        Clk = 1'b0;
    logic        Rstn = 1'b0;
    logic [15:0] Data_i16b = 16'h0000;
    logic        Rw_i = 1'b0;
    logic        Val_i = 1'b0;
    logic        Rdy_o;
    logic [7:0]  Data_o8b;
    logic        Nack_o;
    logic        Scl_oe_o;
    logic        Sda_oe_o;
    logic        Sda_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       slave_pull = 1'b0;
    logic       present = 1'b1;
    logic       skip = 1'b0;
    logic       slave_tx = 1'b0;
    logic       addr_ok = 1'b0;
    logic       first = 1'b0;
    logic       master_ack = 1'b0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] rd_data = 8'h25;
    logic [7:0] bytes[$];
    int bitcnt = 0;
    int starts = 0;
    int stops = 0;
    int start_cyc = 0;
    int stop_cyc = 0;
    int rises = 0;
    int last_rise = 0;
    int min_p = 1000000;
    int max_p = 0;

    wire scl_line = ~Scl_oe_o;
    wire sda_line = ~(Sda_oe_o | slave_pull);
    assign Sda_i = sda_line;

    si5338_i2c_master dut (
        .Clk       (Clk),
        .Rstn      (Rstn),
        .Data_i16b (Data_i16b),
        .Rw_i      (Rw_i),
        .Val_i     (Val_i),
        .Rdy_o     (Rdy_o),
        .Data_o8b  (Data_o8b),
        .Nack_o    (Nack_o),
        .Scl_oe_o  (Scl_oe_o),
        .Sda_oe_o  (Sda_oe_o),
        .Sda_i     (Sda_i)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    // Slave: START/STOP detection and bit-level byte handling.
    always @(negedge sda_line) begin
        if (scl_line) begin
            starts++;
            start_cyc = cyc;
            bitcnt = 0;
            skip = 1'b1;
            first = 1'b1;
            slave_tx = 1'b0;
            slave_pull = 1'b0;
        end
    end

    always @(posedge sda_line) begin
        if (scl_line) begin
            stops++;
            stop_cyc = cyc;
        end
    end

    always @(posedge scl_line) begin
        if (rises > 0) begin
            if (cyc - last_rise < min_p) min_p = cyc - last_rise;
            if (cyc - last_rise > max_p) max_p = cyc - last_rise;
        end
        rises++;
        last_rise = cyc;
        if (bitcnt < 8 && !slave_tx) shreg = {shreg[6:0], sda_line};
        if (bitcnt == 8 && slave_tx) master_ack = sda_line;
    end

    always @(negedge scl_line) begin
        if (skip) begin
            skip = 1'b0;
        end else if (slave_tx) begin
            if (bitcnt < 7) begin
                bitcnt++;
                slave_pull = ~rd_data[7 - bitcnt];
            end else if (bitcnt == 7) begin
                bitcnt = 8;
                slave_pull = 1'b0;
            end else begin
                bitcnt = 0;
                slave_tx = 1'b0;
            end
        end else begin
            if (bitcnt < 7) begin
                bitcnt++;
            end else if (bitcnt == 7) begin
                bytes.push_back(shreg);
                if (first) addr_ok = present && (shreg[7:1] == 7'h70);
                slave_pull = addr_ok;
                bitcnt = 8;
            end else begin
                slave_pull = 1'b0;
                bitcnt = 0;
                if (first && addr_ok && shreg[0]) begin
                    slave_tx = 1'b1;
                    slave_pull = ~rd_data[7];
                end
                first = 1'b0;
            end
        end
    end

    task automatic clr_mon();
        bytes.delete();
        starts = 0;
        stops = 0;
        rises = 0;
        min_p = 1000000;
        max_p = 0;
        master_ack = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic rw);
        @(negedge Clk);
        Data_i16b = d;
        Rw_i = rw;
        Val_i = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Val_i = 1'b0;
    endtask

    // Counts clock edges after the accepting edge until Rdy_o is seen high.
    task automatic wait_rdy(input bit poke, output int n);
        n = 0;
        while (n < 12000) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            if (poke && n == 1000) begin
                Val_i = 1'b1;
                Data_i16b = 16'hFFFF;
            end
            if (poke && n == 1001) Val_i = 1'b0;
            if (Rdy_o) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        checks++; if (Rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", Rdy_o); end
        checks++; if (Data_o8b !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", Data_o8b); end
        checks++; if (Nack_o !== 1'b0) begin errors++; $display("FAIL reset_nack: got %b expected 0", Nack_o); end
        checks++; if (Scl_oe_o !== 1'b0) begin errors++; $display("FAIL reset_scl: got %b expected 0", Scl_oe_o); end
        checks++; if (Sda_oe_o !== 1'b0) begin errors++; $display("FAIL reset_sda: got %b expected 0", Sda_oe_o); end
        Rstn = 1'b1;
        repeat (2) @(negedge Clk);
        checks++; if (Rdy_o !== 1'b1) begin errors++; $display("FAIL post_reset_rdy: got %b expected 1", Rdy_o); end
    endtask

    task automatic test_write();
        int n;
        logic [7:0] exp_b[3] = '{8'hE0, 8'hE6, 8'h10};
        clr_mon();
        send(16'hE610, 1'b0);
        checks++; if (Rdy_o !== 1'b0) begin errors++; $display("FAIL wr_rdy_drop: got %b expected 0", Rdy_o); end
        wait_rdy(1'b1, n);
        checks++; if (n != 29 * BIT) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", n, 29 * BIT); end
        checks++; if (Nack_o !== 1'b0) begin errors++; $display("FAIL wr_nack: got %b expected 0", Nack_o); end
        checks++; if (Data_o8b !== 8'h00) begin errors++; $display("FAIL wr_data_hold: got %h expected 00", Data_o8b); end
        checks++;
        if (bytes.size() != 3) begin
            errors++; $display("FAIL wr_byte_count: got %0d expected 3", bytes.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (bytes[i] !== exp_b[i]) begin errors++; $display("FAIL wr_byte%0d: got %h expected %h", i, bytes[i], exp_b[i]); end
            end
        end
        checks++; if (starts != 1) begin errors++; $display("FAIL wr_starts: got %0d expected 1", starts); end
        checks++; if (stops != 1) begin errors++; $display("FAIL wr_stops: got %0d expected 1", stops); end
        checks++; if (min_p != BIT || max_p != BIT) begin errors++; $display("FAIL wr_scl_period: got %0d..%0d expected %0d", min_p, max_p, BIT); end
    endtask

    task automatic test_read();
        int n;
        logic [7:0] exp_b[3] = '{8'hE0, 8'hDA, 8'hE1};
        clr_mon();
        rd_data = 8'h25;
        send(16'hDA00, 1'b1);
        checks++; if (Data_o8b !== 8'h00) begin errors++; $display("FAIL rd_data_early: got %h expected 00", Data_o8b); end
        wait_rdy(1'b0, n);
        checks++; if (n != 39 * BIT) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", n, 39 * BIT); end
        checks++; if (Data_o8b !== 8'h25) begin errors++; $display("FAIL rd_data: got %h expected 25", Data_o8b); end
        checks++; if (Nack_o !== 1'b0) begin errors++; $display("FAIL rd_nack: got %b expected 0", Nack_o); end
        checks++;
        if (bytes.size() != 3) begin
            errors++; $display("FAIL rd_byte_count: got %0d expected 3", bytes.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (bytes[i] !== exp_b[i]) begin errors++; $display("FAIL rd_byte%0d: got %h expected %h", i, bytes[i], exp_b[i]); end
            end
        end
        checks++; if (starts != 2) begin errors++; $display("FAIL rd_starts: got %0d expected 2", starts); end
        checks++; if (stops != 1) begin errors++; $display("FAIL rd_stops: got %0d expected 1", stops); end
        checks++; if (master_ack !== 1'b1) begin errors++; $display("FAIL rd_master_nack: got %b expected 1", master_ack); end
        checks++; if (min_p != BIT || max_p != BIT) begin errors++; $display("FAIL rd_scl_period: got %0d..%0d expected %0d", min_p, max_p, BIT); end
    endtask

    task automatic test_no_device();
        int n;
        clr_mon();
        present = 1'b0;
        send(16'hE610, 1'b0);
        wait_rdy(1'b0, n);
        present = 1'b1;
        checks++; if (n != 11 * BIT) begin errors++; $display("FAIL nd_latency: got %0d expected %0d", n, 11 * BIT); end
        checks++; if (Nack_o !== 1'b1) begin errors++; $display("FAIL nd_nack: got %b expected 1", Nack_o); end
        checks++; if (Data_o8b !== 8'h25) begin errors++; $display("FAIL nd_data_hold: got %h expected 25", Data_o8b); end
        checks++; if (bytes.size() != 1) begin errors++; $display("FAIL nd_byte_count: got %0d expected 1", bytes.size()); end
        checks++; if (stops != 1) begin errors++; $display("FAIL nd_stops: got %0d expected 1", stops); end
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        int stop1;
        logic [7:0] exp_b[6] = '{8'hE0, 8'h05, 8'h01, 8'hE0, 8'h06, 8'h02};
        clr_mon();
        @(negedge Clk);
        Data_i16b = 16'h0501;
        Rw_i = 1'b0;
        Val_i = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Data_i16b = 16'h0602;
        checks++; if (Nack_o !== 1'b0) begin errors++; $display("FAIL b2b_nack_clear: got %b expected 0", Nack_o); end
        wait_rdy(1'b0, n1);
        stop1 = stop_cyc;
        @(posedge Clk);
        @(negedge Clk);
        Val_i = 1'b0;
        checks++; if (Rdy_o !== 1'b0) begin errors++; $display("FAIL b2b_accept: got rdy %b expected 0", Rdy_o); end
        wait_rdy(1'b0, n2);
        checks++; if (n1 != 29 * BIT) begin errors++; $display("FAIL b2b_latency1: got %0d expected %0d", n1, 29 * BIT); end
        checks++; if (n2 != 29 * BIT) begin errors++; $display("FAIL b2b_latency2: got %0d expected %0d", n2, 29 * BIT); end
        checks++; if (start_cyc - stop1 < BIT) begin errors++; $display("FAIL b2b_bus_free: got %0d expected >= %0d", start_cyc - stop1, BIT); end
        checks++; if (starts != 2 || stops != 2) begin errors++; $display("FAIL b2b_framing: got %0d/%0d expected 2/2", starts, stops); end
        checks++;
        if (bytes.size() != 6) begin
            errors++; $display("FAIL b2b_byte_count: got %0d expected 6", bytes.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (bytes[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, bytes[i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_txn();
        int n;
        int k;
        logic [7:0] exp_b[3] = '{8'hE0, 8'h31, 8'h80};
        send(16'h3180, 1'b0);
        repeat (12 * BIT) @(posedge Clk);
        k = 0;
        @(negedge Clk);
        while (!Scl_oe_o && k < 500) begin
            @(negedge Clk);
            k++;
        end
        #2 Rstn = 1'b0;
        #1;
        checks++; if (Scl_oe_o !== 1'b0) begin errors++; $display("FAIL mid_rst_scl: got %b expected 0", Scl_oe_o); end
        checks++; if (Sda_oe_o !== 1'b0) begin errors++; $display("FAIL mid_rst_sda: got %b expected 0", Sda_oe_o); end
        checks++; if (Rdy_o !== 1'b1) begin errors++; $display("FAIL mid_rst_rdy: got %b expected 1", Rdy_o); end
        checks++; if (Data_o8b !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h expected 00", Data_o8b); end
        @(negedge Clk);
        Rstn = 1'b1;
        repeat (2) @(negedge Clk);
        clr_mon();
        send(16'h3180, 1'b0);
        wait_rdy(1'b0, n);
        checks++; if (n != 29 * BIT) begin errors++; $display("FAIL mid_rst_latency: got %0d expected %0d", n, 29 * BIT); end
        checks++; if (Nack_o !== 1'b0) begin errors++; $display("FAIL mid_rst_nack: got %b expected 0", Nack_o); end
        checks++;
        if (bytes.size() != 3) begin
            errors++; $display("FAIL mid_rst_byte_count: got %0d expected 3", bytes.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (bytes[i] !== exp_b[i]) begin errors++; $display("FAIL mid_rst_byte%0d: got %h expected %h", i, bytes[i], exp_b[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_no_device();
        test_back_to_back();
        test_reset_mid_txn();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
